// File: rtl/insn_stream_encoder_pkg.sv
// Shared definitions for the instruction stream encoder: opcodes, request kinds,
// encoder states and the terminating HLT word.
package insn_stream_encoder_pkg;

    // Machine opcodes, bits [8:4] of every instruction word.
    typedef enum logic [4:0] {
        NOP      = 5'h00,
        ADD      = 5'h01,
        SUB      = 5'h02,
        LD       = 5'h03,
        ST       = 5'h04,
        SET_H    = 5'h10,
        SET_L    = 5'h11,
        LD_LUT_H = 5'h12,
        LD_LUT_L = 5'h13,
        HLT      = 5'h1F
    } opcode_t;

    // High-level request kinds accepted from the program loader.
    typedef enum logic [1:0] {
        K_PLAIN,
        K_IMM8,
        K_LUT8,
        K_HALT
    } enc_kind_t;

    localparam logic [8:0] HLT_WORD = 9'h1FF;

    typedef enum logic [2:0] {
        StIdle,
        StEmit1,
        StEmitHi,
        StEmitLo,
        StHalted
    } enc_state_t;

endpackage

// File: rtl/insn_stream_encoder_if.sv
// Request handshake and instruction-memory write bus of the encoder.
// slave: the encoder; master: the program loader / memory-side observer.
interface insn_stream_encoder_if #(
    parameter int unsigned ADDR_W = 8
);
    import insn_stream_encoder_pkg::*;

    logic              Req_Valid;
    logic              Req_Ready;
    enc_kind_t         Req_Kind;
    logic [4:0]        Req_Op;
    logic [7:0]        Req_Data;
    logic              Imem_Wr_En;
    logic [ADDR_W-1:0] Imem_Addr;
    logic [8:0]        Imem_Wr_Data;

    modport slave (
        input  Req_Valid, Req_Kind, Req_Op, Req_Data,
        output Req_Ready, Imem_Wr_En, Imem_Addr, Imem_Wr_Data
    );

    modport master (
        output Req_Valid, Req_Kind, Req_Op, Req_Data,
        input  Req_Ready, Imem_Wr_En, Imem_Addr, Imem_Wr_Data
    );

endinterface

// File: rtl/insn_stream_encoder_pack.sv
// insn_pack: pure combinational mapper from a request to one 9-bit machine word.
// half_i selects the low-nibble word of a two-word pseudo-op (ignored otherwise).
module insn_pack
    import insn_stream_encoder_pkg::*;
(
    input  enc_kind_t  kind_i,
    input  logic [4:0] op_i,
    input  logic [7:0] data_i,
    input  logic       half_i,
    output logic [8:0] word_o
);

    // Select opcode and nibble for the requested kind and half.
    always_comb begin
        word_o = '0;
        unique case (kind_i)
            K_PLAIN: word_o = {op_i, data_i[3:0]};
            K_IMM8:  word_o = half_i ? {SET_L, data_i[3:0]} : {SET_H, data_i[7:4]};
            K_LUT8:  word_o = half_i ? {LD_LUT_L, data_i[3:0]} : {LD_LUT_H, data_i[7:4]};
            K_HALT:  word_o = HLT_WORD;
        endcase
    end

endmodule

// File: rtl/insn_stream_encoder.sv
// Instruction stream encoder: turns loader requests into machine words and writes
// them sequentially into instruction memory, always keeping one slot for HLT.
// Optional feature macro: ENCODER_CHECKSUM_EN (running XOR of written words).
module insn_stream_encoder
    import insn_stream_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Clear,
    insn_stream_encoder_if.slave bus,
    output logic [ADDR_W:0]      Word_Count,
    output logic                 Done,
    output logic                 Overflow,
    output logic [8:0]           Checksum
);

    localparam int unsigned     Depth   = 1 << ADDR_W;
    // Highest fill a non-HALT request may reach; the last slot belongs to HLT.
    localparam logic [ADDR_W+1:0] MaxFill = (ADDR_W+2)'(Depth - 1);

    enc_state_t        state_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [8:0]        data_q;
    logic [8:0]        lo_q;
    logic [ADDR_W:0]   count_q;
    logic              done_q;
    logic              ovf_q;
`ifdef ENCODER_CHECKSUM_EN
    logic [8:0]        csum_q;
`endif

    logic [8:0]        first_word;
    logic [8:0]        second_word;
    logic              two_word;
    logic [ADDR_W+1:0] fill_after;
    logic              fits;

    insn_pack u_pack_hi (
        .kind_i (bus.Req_Kind),
        .op_i   (bus.Req_Op),
        .data_i (bus.Req_Data),
        .half_i (1'b0),
        .word_o (first_word)
    );

    insn_pack u_pack_lo (
        .kind_i (bus.Req_Kind),
        .op_i   (bus.Req_Op),
        .data_i (bus.Req_Data),
        .half_i (1'b1),
        .word_o (second_word)
    );

    assign two_word   = (bus.Req_Kind == K_IMM8) || (bus.Req_Kind == K_LUT8);
    assign fill_after = {1'b0, count_q} + (two_word ? (ADDR_W+2)'(2) : (ADDR_W+2)'(1));
    assign fits       = (bus.Req_Kind == K_HALT) || (fill_after <= MaxFill);

    // Encoder FSM with registered memory outputs and status flags.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            lo_q    <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef ENCODER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else if (Clear) begin
            state_q <= StIdle;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            lo_q    <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef ENCODER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Req_Ready is high throughout this state
                    if (bus.Req_Valid) begin
                        if (!fits) begin
                            ovf_q <= 1'b1;
                        end else begin
                            wr_en_q <= 1'b1;
                            addr_q  <= count_q[ADDR_W-1:0];
                            data_q  <= first_word;
                            lo_q    <= second_word;
                            count_q <= count_q + (ADDR_W+1)'(1);
`ifdef ENCODER_CHECKSUM_EN
                            csum_q  <= csum_q ^ first_word;
`endif
                            if (first_word == HLT_WORD) begin
                                done_q <= 1'b1;
                            end
                            state_q <= two_word ? StEmitHi : StEmit1;
                        end
                    end
                end
                StEmit1: state_q <= done_q ? StHalted : StIdle;
                StEmitHi: begin
                    wr_en_q <= 1'b1;
                    addr_q  <= count_q[ADDR_W-1:0];
                    data_q  <= lo_q;
                    count_q <= count_q + (ADDR_W+1)'(1);
`ifdef ENCODER_CHECKSUM_EN
                    csum_q  <= csum_q ^ lo_q;
`endif
                    state_q <= StEmitLo;
                end
                StEmitLo: state_q <= StIdle;
                StHalted: state_q <= StHalted;
                default:  state_q <= StIdle;
            endcase
        end
    end

    // Ready is held low while reset is asserted, not just in the idle state.
    assign bus.Req_Ready    = (state_q == StIdle) && Reset;
    assign bus.Imem_Wr_En   = wr_en_q;
    assign bus.Imem_Addr    = addr_q;
    assign bus.Imem_Wr_Data = data_q;
    assign Word_Count       = count_q;
    assign Done             = done_q;
    assign Overflow         = ovf_q;
`ifdef ENCODER_CHECKSUM_EN
    assign Checksum         = csum_q;
`else
    assign Checksum         = '0;
`endif

endmodule

// File: tb/tb_insn_stream_encoder.sv
// Bench for insn_stream_encoder: one DUT at ADDR_W=8 and one at ADDR_W=2, a
// transaction-level model of both, a per-cycle compare and literal spot checks.
module tb_insn_stream_encoder;
    import insn_stream_encoder_pkg::*;

    logic Clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    always #5 Clk = ~Clk;

    // Bench-side request drivers, index 0 = big DUT, 1 = small DUT.
    logic       v  [2];
    enc_kind_t  k  [2];
    logic [4:0] op [2];
    logic [7:0] d  [2];

    insn_stream_encoder_if #(.ADDR_W(8)) if_big ();
    insn_stream_encoder_if #(.ADDR_W(2)) if_small ();

    logic [8:0] wc_big;
    logic [2:0] wc_small;
    logic       done_o [2];
    logic       ovf_o  [2];
    logic [8:0] cs_o   [2];

    assign if_big.Req_Valid   = v[0];
    assign if_big.Req_Kind    = k[0];
    assign if_big.Req_Op      = op[0];
    assign if_big.Req_Data    = d[0];
    assign if_small.Req_Valid = v[1];
    assign if_small.Req_Kind  = k[1];
    assign if_small.Req_Op    = op[1];
    assign if_small.Req_Data  = d[1];

    insn_stream_encoder #(.ADDR_W(8)) u_big (
        .Clk        (Clk),
        .Reset      (rst_n),
        .Clear      (clear),
        .bus        (if_big),
        .Word_Count (wc_big),
        .Done       (done_o[0]),
        .Overflow   (ovf_o[0]),
        .Checksum   (cs_o[0])
    );

    insn_stream_encoder #(.ADDR_W(2)) u_small (
        .Clk        (Clk),
        .Reset      (rst_n),
        .Clear      (clear),
        .bus        (if_small),
        .Word_Count (wc_small),
        .Done       (done_o[1]),
        .Overflow   (ovf_o[1]),
        .Checksum   (cs_o[1])
    );

    // Uniform 32-bit views of both DUTs' outputs.
    logic [31:0] rdy [2], we [2], addr [2], wdat [2], cnt [2];
    assign rdy[0]  = 32'(if_big.Req_Ready);
    assign we[0]   = 32'(if_big.Imem_Wr_En);
    assign addr[0] = 32'(if_big.Imem_Addr);
    assign wdat[0] = 32'(if_big.Imem_Wr_Data);
    assign cnt[0]  = 32'(wc_big);
    assign rdy[1]  = 32'(if_small.Req_Ready);
    assign we[1]   = 32'(if_small.Imem_Wr_En);
    assign addr[1] = 32'(if_small.Imem_Addr);
    assign wdat[1] = 32'(if_small.Imem_Wr_Data);
    assign cnt[1]  = 32'(wc_small);

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] @%0t: got %0h, expected %0h", nm, i, $time, act, exp);
        end
    endfunction

    // ---------------- Behavioural model ----------------
    // Each accepted request becomes a list of words; the first shows up on the
    // bus in the cycle after acceptance, a second one in the cycle after that.
    int         depth [2] = '{256, 4};
    int         m_cnt [2], m_addr [2];
    bit         m_we [2], m_done [2], m_ovf [2], m_pv [2];
    logic [8:0] m_data [2], m_csum [2], m_pend [2];

    always @(posedge Clk or negedge rst_n) begin
        int n, cnt_n, addr_n;
        bit we_n, done_n, ovf_n, pv_n, accept_now;
        logic [8:0] w0, w1, data_n, cs_n, pend_n;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] <= 0; m_addr[i] <= 0; m_we[i] <= 0; m_done[i] <= 0;
                m_ovf[i] <= 0; m_pv[i] <= 0; m_data[i] <= '0; m_csum[i] <= '0;
                m_pend[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                cnt_n = m_cnt[i]; addr_n = m_addr[i]; data_n = m_data[i];
                done_n = m_done[i]; ovf_n = m_ovf[i]; cs_n = m_csum[i];
                pv_n = m_pv[i]; pend_n = m_pend[i]; we_n = 0;
                w0 = '0; w1 = '0; n = 0; accept_now = 0;
                if (clear) begin
                    cnt_n = 0; addr_n = 0; done_n = 0; ovf_n = 0; cs_n = '0; pv_n = 0;
                end else if (m_pv[i]) begin
                    we_n = 1; addr_n = cnt_n % depth[i]; data_n = m_pend[i];
                    cnt_n++; cs_n ^= m_pend[i]; pv_n = 0;
                end else if (v[i] && !m_we[i] && !m_done[i]) begin
                    case (k[i])
                        K_PLAIN: begin n = 1; w0 = {op[i], d[i][3:0]}; end
                        K_IMM8:  begin n = 2; w0 = {SET_H, d[i][7:4]}; w1 = {SET_L, d[i][3:0]}; end
                        K_LUT8:  begin
                            n = 2; w0 = {LD_LUT_H, d[i][7:4]}; w1 = {LD_LUT_L, d[i][3:0]};
                        end
                        default: begin n = 1; w0 = 9'h1FF; end
                    endcase
                    if (k[i] != K_HALT && cnt_n + n > depth[i] - 1) ovf_n = 1;
                    else accept_now = 1;
                end
                if (accept_now) begin
                    we_n = 1; addr_n = cnt_n % depth[i]; data_n = w0;
                    cnt_n++; cs_n ^= w0;
                    if (w0 == 9'h1FF) done_n = 1;
                    if (n == 2) begin pv_n = 1; pend_n = w1; end
                end
                m_cnt[i] <= cnt_n; m_addr[i] <= addr_n; m_we[i] <= we_n;
                m_data[i] <= data_n; m_done[i] <= done_n; m_ovf[i] <= ovf_n;
                m_csum[i] <= cs_n; m_pv[i] <= pv_n; m_pend[i] <= pend_n;
            end
        end
    end

    // Per-cycle compare of both DUTs against the model, mid-cycle.
    always @(negedge Clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("ready", i, rdy[i], 32'(rst_n && !m_we[i] && !m_done[i]));
            chk("wr_en", i, we[i], 32'(m_we[i]));
            if (m_we[i]) begin
                chk("addr", i, addr[i], 32'(m_addr[i]));
                chk("wdata", i, wdat[i], 32'(m_data[i]));
            end
            chk("count", i, cnt[i], 32'(m_cnt[i]));
            chk("done", i, 32'(done_o[i]), 32'(m_done[i]));
            chk("ovf", i, 32'(ovf_o[i]), 32'(m_ovf[i]));
`ifdef ENCODER_CHECKSUM_EN
            chk("csum", i, 32'(cs_o[i]), 32'(m_csum[i]));
`else
            chk("csum", i, 32'(cs_o[i]), 32'h0);
`endif
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic send(input int i, input enc_kind_t kk, input logic [4:0] oo,
                        input logic [7:0] dd, input int max_cyc, output bit acc);
        acc = 0;
        @(negedge Clk); #1;
        v[i] = 1'b1; k[i] = kk; op[i] = oo; d[i] = dd;
        for (int c = 0; c < max_cyc && !acc; c++) begin
            if (rdy[i] == 32'd1) acc = 1;
            @(posedge Clk); #1;
        end
        // Returns mid-way through the cycle after acceptance (first write cycle).
        @(negedge Clk); #1;
        v[i] = 1'b0;
    endtask

    task automatic send_ok(input int i, input enc_kind_t kk, input logic [4:0] oo,
                           input logic [7:0] dd);
        bit acc;
        send(i, kk, oo, dd, 8, acc);
        chk("accept", i, 32'(acc), 32'd1);
    endtask

    task automatic pulse_clear();
        @(negedge Clk); #1; clear = 1'b1;
        @(negedge Clk); #1; clear = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge Clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; k[i] = K_PLAIN; op[i] = '0; d[i] = '0;
        end
        // Reset state on both DUTs
        repeat (3) @(negedge Clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", i, rdy[i], 0);
            chk("rst_we", i, we[i], 0);
            chk("rst_addr", i, addr[i], 0);
            chk("rst_data", i, wdat[i], 0);
            chk("rst_count", i, cnt[i], 0);
            chk("rst_flags", i, {30'd0, done_o[i], ovf_o[i]}, 0);
            chk("rst_csum", i, 32'(cs_o[i]), 0);
        end
        rst_n = 1'b1;
        next_cycle();
        chk("ready_after_rst", 0, rdy[0], 1);

        // Single plain word
        send_ok(0, K_PLAIN, ADD, 8'h03);
        chk("plain_we", 0, we[0], 1);
        chk("plain_addr", 0, addr[0], 0);
        chk("plain_data", 0, wdat[0], 32'h013);
        chk("plain_count", 0, cnt[0], 1);
        chk("plain_ready", 0, rdy[0], 0);
`ifdef ENCODER_CHECKSUM_EN
        chk("plain_csum", 0, 32'(cs_o[0]), 32'h013);
`else
        chk("plain_csum", 0, 32'(cs_o[0]), 0);
`endif
        next_cycle();
        chk("plain_ready_back", 0, rdy[0], 1);
        chk("plain_we_off", 0, we[0], 0);

        // HLT opcode with a non-F operand does not halt
        send_ok(0, K_PLAIN, HLT, 8'h03);
        chk("fake_hlt_data", 0, wdat[0], 32'h1F3);
        chk("fake_hlt_done", 0, 32'(done_o[0]), 0);
        next_cycle();
        chk("fake_hlt_ready", 0, rdy[0], 1);

        // Immediate pseudo-op pair
        pulse_clear();
        chk("clear_count", 0, cnt[0], 0);
        send_ok(0, K_IMM8, NOP, 8'hA5);
        chk("imm_hi_addr", 0, addr[0], 0);
        chk("imm_hi_data", 0, wdat[0], 32'h10A);
        chk("imm_hi_ready", 0, rdy[0], 0);
        next_cycle();
        chk("imm_lo_addr", 0, addr[0], 1);
        chk("imm_lo_data", 0, wdat[0], 32'h115);
        chk("imm_lo_ready", 0, rdy[0], 0);
        next_cycle();
        chk("imm_done_ready", 0, rdy[0], 1);
        chk("imm_count", 0, cnt[0], 2);

        // LUT pair, then HALT; nothing is acknowledged afterwards
        pulse_clear();
        send_ok(0, K_LUT8, NOP, 8'h3C);
        chk("lut_hi_data", 0, wdat[0], 32'h123);
        next_cycle();
        chk("lut_lo_data", 0, wdat[0], 32'h13C);
        send_ok(0, K_HALT, NOP, 8'h00);
        chk("halt_addr", 0, addr[0], 2);
        chk("halt_data", 0, wdat[0], 32'h1FF);
        chk("halt_done", 0, 32'(done_o[0]), 1);
        chk("halt_count", 0, cnt[0], 3);
`ifdef ENCODER_CHECKSUM_EN
        chk("halt_csum", 0, 32'(cs_o[0]), 32'h1E0);
`endif
        send(0, K_PLAIN, ADD, 8'h01, 6, acc);
        chk("halted_no_ack", 0, 32'(acc), 0);
        pulse_clear();
        chk("clear_done", 0, 32'(done_o[0]), 0);
        chk("clear_ready", 0, rdy[0], 1);

        // Capacity on the 4-deep DUT: one slot stays reserved for HLT
        send_ok(1, K_PLAIN, SUB, 8'h01);
        chk("cap_w0", 1, wdat[1], 32'h021);
        send_ok(1, K_PLAIN, SUB, 8'h02);
        chk("cap_w1_addr", 1, addr[1], 1);
        send_ok(1, K_IMM8, NOP, 8'h77);
        chk("cap_imm_drop_we", 1, we[1], 0);
        chk("cap_imm_drop_ovf", 1, 32'(ovf_o[1]), 1);
        chk("cap_imm_drop_cnt", 1, cnt[1], 2);
        send_ok(1, K_PLAIN, SUB, 8'h03);
        chk("cap_w2_addr", 1, addr[1], 2);
        chk("cap_w2_data", 1, wdat[1], 32'h023);
        send_ok(1, K_PLAIN, SUB, 8'h04);
        chk("cap_plain_drop_we", 1, we[1], 0);
        chk("cap_plain_drop_cnt", 1, cnt[1], 3);
        send_ok(1, K_HALT, NOP, 8'h00);
        chk("cap_halt_addr", 1, addr[1], 3);
        chk("cap_halt_data", 1, wdat[1], 32'h1FF);
        chk("cap_halt_cnt", 1, cnt[1], 4);
        chk("cap_halt_done", 1, 32'(done_o[1]), 1);
        pulse_clear();

        // Async reset during the low word of a pair
        send_ok(0, K_IMM8, NOP, 8'hFF);
        chk("rmid_hi", 0, wdat[0], 32'h10F);
        @(posedge Clk); #1;
        chk("rmid_lo_we", 0, we[0], 1);
        chk("rmid_lo", 0, wdat[0], 32'h11F);
        rst_n = 1'b0;
        #1;
        chk("rmid_we", 0, we[0], 0);
        chk("rmid_addr", 0, addr[0], 0);
        chk("rmid_data", 0, wdat[0], 0);
        chk("rmid_count", 0, cnt[0], 0);
        chk("rmid_ready", 0, rdy[0], 0);
        next_cycle();
        rst_n = 1'b1;
        send_ok(0, K_PLAIN, ADD, 8'h05);
        chk("rpost_addr", 0, addr[0], 0);
        chk("rpost_data", 0, wdat[0], 32'h015);
        chk("rpost_count", 0, cnt[0], 1);

        // Synchronous Clear during the low word of a pair
        send_ok(0, K_IMM8, NOP, 8'hFF);
        @(posedge Clk); #1;
        clear = 1'b1;
        #1;
        chk("cmid_still_we", 0, we[0], 1);
        chk("cmid_still_cnt", 0, cnt[0], 3);
        @(posedge Clk); #1;
        clear = 1'b0;
        chk("cmid_we", 0, we[0], 0);
        chk("cmid_count", 0, cnt[0], 0);
        chk("cmid_ready", 0, rdy[0], 1);
        send_ok(0, K_PLAIN, ADD, 8'h06);
        chk("cpost_addr", 0, addr[0], 0);
        chk("cpost_data", 0, wdat[0], 32'h016);

        repeat (4) next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/insn_stream_encoder.md
Name: insn_stream_encoder

Overview:
- Encodes a stream of high-level instruction requests into 9-bit machine words and writes them sequentially into instruction memory.
- Word format: opcode in [8:4], 4-bit operand in [3:0].
- Expands 8-bit-immediate pseudo-ops into their hi/lo nibble pairs (SET_H/SET_L, LD_LUT_H/LD_LUT_L).
- Terminates the program with the all-ones HLT word, which raises the control decoder's DONE flag. Sits between the test host / program loader and instruction memory.

Parameters:
ADDR_W, 8, instruction memory address width; capacity DEPTH = 2**ADDR_W words

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
Clear  input  1  synchronous restart: address and flags to zero, state IDLE
Req_Valid  input  1  request present
Req_Ready  output  1  encoder can accept a request this cycle
Req_Kind  input  2  enc_kind_t: K_PLAIN, K_IMM8, K_LUT8, K_HALT
Req_Op  input  5  opcode (used by K_PLAIN only)
Req_Data  input  8  K_PLAIN: [3:0] operand; K_IMM8/K_LUT8: 8-bit value
Imem_Wr_En  output  1  write strobe, one word per asserted cycle
Imem_Addr  output  ADDR_W  write address
Imem_Wr_Data  output  9  encoded machine word
Word_Count  output  ADDR_W+1  words written since reset/Clear
Done  output  1  HLT written; sticky
Overflow  output  1  request dropped for lack of space; sticky
Checksum  output  9  see Optional Feature

Behaviour:
- Reset (async, Reset low): state IDLE. Req_Ready=0 while in reset. Imem_Wr_En=0, Imem_Addr=0, Imem_Wr_Data=0, Word_Count=0, Done=0, Overflow=0, Checksum=0.
- Handshake: transfer occurs when Req_Valid & Req_Ready at a rising edge. Req_Ready=1 only in IDLE.
- All memory outputs are registered. First word appears with Imem_Wr_En=1 in the cycle after acceptance.
- Imem_Addr equals the write pointer during the write cycle. The pointer increments after each write.
- Encoding:
  - K_PLAIN -> {Req_Op, Req_Data[3:0]} (1 word).
  - K_IMM8 -> {SET_H, d[7:4]} then {SET_L, d[3:0]} (2 words).
  - K_LUT8 -> {LD_LUT_H, d[7:4]} then {LD_LUT_L, d[3:0]} (2 words).
  - K_HALT -> 9'h1FF (1 word).
- States:
  - IDLE: accept request. 1-word kinds go to EMIT1; 2-word kinds go to EMIT_HI.
  - EMIT1: write the word; return to IDLE, or go to HALTED if the word is HLT.
  - EMIT_HI: write hi word -> EMIT_LO.
  - EMIT_LO: write lo word -> IDLE.
  - HALTED: Req_Ready=0, no writes, Done=1; exit only via Clear or Reset.
- A 2-word request is never split. Req_Ready stays 0 during EMIT_HI/EMIT_LO, so sustained throughput is 1 request per 2 cycles (1-word) or per 3 cycles (2-word).
- Capacity rule: one slot is always reserved for HLT.
  - A non-HALT request of n words is written only if Word_Count + n <= DEPTH-1.
  - Otherwise it is still accepted but discarded: no write, Overflow set, state stays IDLE.
  - K_HALT always fits.
- K_PLAIN with Req_Op equal to the HLT opcode is written verbatim with operand as given. It does not enter HALTED unless the word equals 9'h1FF.
- Clear has priority over a simultaneous handshake. An in-flight EMIT_LO is abandoned, so the hi word stays in memory but Word_Count resets.
- Reset asserted mid-operation: immediate return to reset values. Partially emitted pairs are not completed.
- Word_Count saturates naturally at DEPTH, reached only via the HLT slot.

Optional Feature:
- Macro ENCODER_CHECKSUM_EN.
- Defined: Checksum = XOR of every 9-bit word written since Reset/Clear, updated in the same cycle as the write.
- Undefined: Checksum is constant 0 and no checksum register is synthesized.

Decomposition:
- Definitions package gains:
  - typedef enum logic [1:0] enc_kind_t {K_PLAIN, K_IMM8, K_LUT8, K_HALT};
  - localparam HLT_WORD = 9'h1FF;
  - encoder state typedef enum enc_state_t.
- Opcodes SET_H, SET_L, LD_LUT_H, LD_LUT_L, HLT are reused from the existing Definitions opcode enum. No numeric values are duplicated.
- One sub-module: insn_pack, a pure combinational {kind, op, data, half} -> 9-bit word mapper, shared with future assembler-side tooling.

Test Plan:
- Reset then K_PLAIN op=ADD data=8'h03 -> 1 cycle later: Imem_Wr_En=1, Addr=0, Data={ADD,4'h3}; Word_Count=1; Req_Ready returns to 1 the cycle after.
- K_IMM8 data=8'hA5 -> words {SET_H,4'hA} at addr 0 and {SET_L,4'h5} at addr 1 on consecutive cycles; Req_Ready=0 for both write cycles.
- K_LUT8 8'h3C then K_HALT -> {LD_LUT_H,3},{LD_LUT_L,C},9'h1FF at addrs 0..2; Done=1; a further Req_Valid is never acknowledged.
- ADDR_W=2 (DEPTH 4): three K_PLAIN, then K_IMM8 -> first three written, IMM8 dropped with Overflow=1; then K_HALT -> written at addr 3, Word_Count=4.
- Assert Reset low during EMIT_LO of K_IMM8 8'hFF -> outputs zero immediately; after release, the next request writes at addr 0. Repeat with Clear -> same result, synchronous.
- With ENCODER_CHECKSUM_EN: words {ADD,3}, 9'h1FF -> Checksum = {ADD,3} ^ 9'h1FF. Without the macro: Checksum=0 throughout.
